// File: rtl/affine_tap_sum.sv
`default_nettype none
// ============================================================================
// Module   : affine_tap_sum
// Purpose  : Signed sum of the six affine-interpolation tap products, followed
//            by round, arithmetic shift and clip to the output sample width.
//            Three-stage valid/ready pipeline with a single global advance.
//            Optional macro AFFINE_TAP_SUM_SAT_CNT_EN adds a 16-bit saturating
//            counter (port sat_cnt) of clipped results handed downstream.
// Revision : 1.0  initial release
// ============================================================================
module affine_tap_sum #(
  parameter int IN_SIZE   = 8,
  parameter int PROD_SIZE = 14,
  parameter int ACC_SIZE  = 17,
  parameter int SHIFT     = 6,
  parameter int OUT_SIZE  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_bypass,
  input  logic signed [IN_SIZE-1:0]   x_center,
  input  logic signed [PROD_SIZE-1:0] p0,
  input  logic signed [PROD_SIZE-1:0] p1,
  input  logic signed [PROD_SIZE-1:0] p2,
  input  logic signed [PROD_SIZE-1:0] p3,
  input  logic signed [PROD_SIZE-1:0] p4,
  input  logic signed [PROD_SIZE-1:0] p5,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_SIZE-1:0]  y,
  output logic                        sat_flag
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
  ,
  output logic [15:0]                 sat_cnt
`endif
);

  localparam logic signed [ACC_SIZE-1:0] c_RND  = ACC_SIZE'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_SIZE-1:0] c_YMAX = ACC_SIZE'(2 ** (OUT_SIZE - 1) - 1);
  localparam logic signed [ACC_SIZE-1:0] c_YMIN = ACC_SIZE'(-(2 ** (OUT_SIZE - 1)));

  // Sign-extend one tap product to the accumulator width.
  function automatic logic signed [ACC_SIZE-1:0] sx(input logic signed [PROD_SIZE-1:0] v);
    return {{(ACC_SIZE - PROD_SIZE){v[PROD_SIZE-1]}}, v};
  endfunction

  logic                        w_adv;
  logic signed [ACC_SIZE-1:0]  w_sa;
  logic signed [ACC_SIZE-1:0]  w_sb;
  logic signed [OUT_SIZE-1:0]  w_xc;
  logic signed [ACC_SIZE-1:0]  w_r;
  logic                        w_hi;
  logic                        w_lo;
  logic signed [OUT_SIZE-1:0]  w_y;

  // Stage 1 registers
  logic                        r_v1;
  logic signed [ACC_SIZE-1:0]  r_sa;
  logic signed [ACC_SIZE-1:0]  r_sb;
  logic                        r_byp1;
  logic signed [OUT_SIZE-1:0]  r_xc1;
  // Stage 2 registers
  logic                        r_v2;
  logic signed [ACC_SIZE-1:0]  r_acc;
  logic                        r_byp2;
  logic signed [OUT_SIZE-1:0]  r_xc2;
  // Stage 3 (output) registers
  logic                        r_out_valid;
  logic signed [OUT_SIZE-1:0]  r_y;
  logic                        r_sat;

  // Whole pipe moves together; it only stalls when a result is waiting.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Taps 1 and 4 carry negative coefficients; products arrive as magnitudes.
  assign w_sa = sx(p0) - sx(p1) + sx(p2);
  assign w_sb = sx(p3) - sx(p4) + sx(p5);

  // Centre sample resized to the output width for the unfiltered path.
  if (OUT_SIZE > IN_SIZE) begin : g_xc_sext
    assign w_xc = OUT_SIZE'(x_center);
  end else begin : g_xc_trunc
    assign w_xc = x_center[OUT_SIZE-1:0];
  end

  // Normalise the rounded accumulator and clip to the signed output range.
  assign w_r  = r_acc >>> SHIFT;
  assign w_hi = (w_r > c_YMAX);
  assign w_lo = (w_r < c_YMIN);
  assign w_y  = w_hi ? c_YMAX[OUT_SIZE-1:0] :
                w_lo ? c_YMIN[OUT_SIZE-1:0] : w_r[OUT_SIZE-1:0];

  // Stage 1: split the six-tap sum into two three-term partial sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_sa   <= '0;
      r_sb   <= '0;
      r_byp1 <= 1'b0;
      r_xc1  <= '0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_sa   <= w_sa;
      r_sb   <= w_sb;
      r_byp1 <= in_bypass;
      r_xc1  <= w_xc;
    end
  end

  // Stage 2: combine partial sums and add the half-LSB rounding offset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_acc  <= '0;
      r_byp2 <= 1'b0;
      r_xc2  <= '0;
    end else if (w_adv) begin
      r_v2   <= r_v1;
      r_acc  <= r_sa + r_sb + c_RND;
      r_byp2 <= r_byp1;
      r_xc2  <= r_xc1;
    end
  end

  // Stage 3: select bypass sample or clipped filter result, flag clipping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_sat       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_v2;
      if (r_byp2) begin
        r_y   <= r_xc2;
        r_sat <= 1'b0;
      end else begin
        r_y   <= w_y;
        r_sat <= w_hi || w_lo;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign sat_flag  = r_sat;

`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  // Count clipped results as they are handed downstream; stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (r_out_valid && out_ready && r_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_affine_tap_sum.sv
`default_nettype none
// ============================================================================
// Module   : tb_affine_tap_sum
// Purpose  : Self-checking bench for affine_tap_sum: directed cases plus
//            randomized traffic scored against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_affine_tap_sum;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_bypass;
  logic signed [7:0] x_center;
  logic signed [13:0] p0, p1, p2, p3, p4, p5;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] y;
  logic              sat_flag;
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
  logic [15:0]       sat_cnt;
`endif

  affine_tap_sum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bypass (in_bypass),
    .x_center  (x_center),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .p5        (p5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat_flag  (sat_flag)
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       sat;
  } exp_t;

  exp_t  exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_out   = 0;
  int    cyc_n   = 0;
  int    exp_cnt = 0;
  string cur_tag = "init";
  int    cq[6];
  int    cxc;
  bit    cbyp;

  // Reference: signed tap sum, round half up, floor-divide by 64, clip.
  function automatic exp_t model(input bit byp, input int xc,
                                 input int q0, input int q1, input int q2,
                                 input int q3, input int q4, input int q5);
    exp_t e;
    int   sum;
    int   t;
    int   r;
    if (byp) begin
      e.y   = 8'(xc);
      e.sat = 1'b0;
      return e;
    end
    sum = q0 - q1 + q2 + q3 - q4 + q5;
    t   = sum + 32;
    r   = (t >= 0) ? (t / 64) : -((-t + 63) / 64);
    if (r > 127) begin
      e.y = 8'(127); e.sat = 1'b1;
    end else if (r < -128) begin
      e.y = 8'(-128); e.sat = 1'b1;
    end else begin
      e.y = 8'(r); e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic set_beat(input bit byp, input int xc, input int q0, input int q1,
                          input int q2, input int q3, input int q4, input int q5);
    cbyp = byp; cxc = xc;
    cq[0] = q0; cq[1] = q1; cq[2] = q2; cq[3] = q3; cq[4] = q4; cq[5] = q5;
    in_bypass = byp;
    x_center  = 8'(xc);
    p0 = 14'(q0); p1 = 14'(q1); p2 = 14'(q2);
    p3 = 14'(q3); p4 = 14'(q4); p5 = 14'(q5);
  endtask

  function automatic int rprod();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  // One clock: score the output handshake, record an accepted beat, advance.
  task automatic cyc();
    exp_t e;
    #1;
    if (out_valid === 1'b1 && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk({cur_tag, "_unexpected_out"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({cur_tag, "_y"}, $signed(y), $signed(e.y));
        chk({cur_tag, "_sat"}, {31'd0, sat_flag}, {31'd0, e.sat});
        if (e.sat) exp_cnt++;
      end
    end
    if (in_valid && in_ready === 1'b1)
      exp_q.push_back(model(cbyp, cxc, cq[0], cq[1], cq[2], cq[3], cq[4], cq[5]));
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Single beat with out_ready high: latency and value check.
  task automatic one_beat(input string tag, input bit byp, input int xc,
                          input int q0, input int q1, input int q2,
                          input int q3, input int q4, input int q5);
    int c0;
    cur_tag   = tag;
    set_beat(byp, xc, q0, q1, q2, q3, q4, q5);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    c0 = cyc_n;
    cyc();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && (cyc_n - c0) < 10) cyc();
    chk({tag, "_latency"}, cyc_n - c0, 3);
    cyc();
  endtask

  initial begin
    int   k;
    int   stall;
    bit   seen;
    int   n0;
    logic signed [7:0] y_hold;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0);
    y_hold = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_y", $signed(y), 0);
    chk("reset_sat", {31'd0, sat_flag}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
    chk("reset_sat_cnt", {16'd0, sat_cnt}, 0);
`endif
    rst_n = 1'b1;
    cyc();

    // Directed single beats
    one_beat("frac1", 0, 0, 10, 30, 630, 40, 20, 10);
    one_beat("pos_sat", 0, 0, 127, -384, 8001, 508, -256, 127);
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
    chk("sat_cnt_after_pos", {16'd0, sat_cnt}, exp_cnt);
`endif
    one_beat("neg_sat", 0, 0, -128, 381, -8064, -512, 254, -128);
    one_beat("bypass", 1, -5, rprod(), rprod(), rprod(), rprod(), rprod(), rprod());
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
    chk("sat_cnt_after_directed", {16'd0, sat_cnt}, exp_cnt);
`endif

    // Backpressure: five beats y=1..5, stall 4 cycles at first output
    cur_tag = "bp"; k = 0; stall = 0; seen = 0; out_ready = 1'b1; n0 = n_out;
    for (int c = 0; c < 40; c++) begin
      if (k >= 5 && exp_q.size() == 0) break;
      if (k < 5) begin
        set_beat(0, 0, k + 1, 3 * (k + 1), 63 * (k + 1), 4 * (k + 1), 2 * (k + 1), k + 1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1 && !seen) begin
        seen = 1; stall = 4; y_hold = y;
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        chk("bp_valid_held", {31'd0, out_valid}, 1);
        if (stall < 4) chk("bp_y_hold", $signed(y), $signed(y_hold));
        stall--;
      end
      if (in_valid && in_ready === 1'b1) k++;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_out_count", n_out - n0, 5);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with three beats in flight
    cur_tag = "rst_mid"; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(0, 0, 7 + i, 3 * (7 + i), 63 * (7 + i), 4 * (7 + i), 2 * (7 + i), 7 + i);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("rst_mid_full", {31'd0, out_valid}, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 0);
    chk("rst_mid_y", $signed(y), 0);
    chk("rst_mid_sat", {31'd0, sat_flag}, 0);
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
    chk("rst_mid_sat_cnt", {16'd0, sat_cnt}, 0);
`endif
    out_ready = 1'b1; n0 = n_out;
    repeat (10) cyc();
    chk("rst_mid_no_out", n_out - n0, 0);

    // Randomized traffic with random backpressure and bypass
    cur_tag = "rand";
    for (int i = 0; i < 400; i++) begin
      set_beat($urandom_range(0, 4) == 0, int'($urandom_range(0, 255)) - 128,
               rprod(), rprod(), rprod(), rprod(), rprod(), rprod());
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
    chk("rand_drained", exp_q.size(), 0);
`ifdef AFFINE_TAP_SUM_SAT_CNT_EN
    chk("rand_sat_cnt", {16'd0, sat_cnt}, exp_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
